// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with two combinational read
// ports, one synchronous write port, optional write-to-read forwarding and a
// per-register busy scoreboard that flags read-after-write hazards.
module register_file_sb #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int NREGS   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [ADDR_W-1:0] a3,
  input  logic [DATA_W-1:0] wd3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              bs_en,
  input  logic [ADDR_W-1:0] bs_addr,
  output logic [NREGS-1:0]  busy,
  output logic              haz1,
  output logic              haz2
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_busy_nxt;
  logic [DATA_W-1:0] w_mem_rd1;
  logic [DATA_W-1:0] w_mem_rd2;
  logic              w_wr_drop;

  // Read-port data selection: reset gating, hardwired zero, forwarding, storage.
  function automatic logic [DATA_W-1:0] sel_read(
    input logic              rst_n,
    input logic [ADDR_W-1:0] a,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    if (!rst_n)                              v = '0;
    else if ((ZERO_REG != 0) && (a == '0))   v = '0;
    else if ((BYPASS != 0) && we3 && (a == a3)) v = wd3;
    else                                     v = stored;
    return v;
  endfunction

  // A pending register hazards unless the writeback completing this cycle
  // is forwarded onto the port.
  function automatic logic sel_haz(
    input logic              rst_n,
    input logic [ADDR_W-1:0] a,
    input logic              pending
  );
    logic h;
    if (!rst_n)                                 h = 1'b0;
    else if ((ZERO_REG != 0) && (a == '0))      h = 1'b0;
    else if ((BYPASS != 0) && we3 && (a == a3)) h = 1'b0;
    else                                        h = pending;
    return h;
  endfunction

  assign w_mem_rd1 = r_mem[a1];
  assign w_mem_rd2 = r_mem[a2];
  assign w_wr_drop = (ZERO_REG != 0) && (a3 == '0);

  // Scoreboard next state: issuing a new producer outranks a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (bs_en && (bs_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0)))
        w_busy_nxt[i] = 1'b1;
      else if (we3 && (a3 == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b0;
    end
  end

  // Register storage and scoreboard update; reset wipes both at the edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_busy <= '0;
    end else begin
      if (we3 && !w_wr_drop) r_mem[a3] <= wd3;
      r_busy <= w_busy_nxt;
    end
  end

  // Combinational read ports and hazard flags.
  always_comb begin
    rd1  = sel_read(rst, a1, w_mem_rd1);
    rd2  = sel_read(rst, a2, w_mem_rd2);
    haz1 = sel_haz(rst, a1, r_busy[a1]);
    haz2 = sel_haz(rst, a2, r_busy[a2]);
  end

  assign busy = r_busy;

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: scoreboard bench for register_file_sb, covering the
// default build, a non-forwarding build and a 32-bit x 16-entry build.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        we3, bs_en;
  logic [2:0]  a1, a2, a3, bs_addr;
  logic [19:0] wd3;
  logic [19:0] rd1, rd2, nb_rd1, nb_rd2;
  logic [7:0]  busy, nb_busy;
  logic        haz1, haz2, nb_haz1, nb_haz2;

  logic        w_we3, w_bs_en;
  logic [3:0]  w_a1, w_a2, w_a3, w_bs_addr;
  logic [31:0] w_wd3, w_rd1, w_rd2;
  logic [15:0] w_busy;
  logic        w_haz1, w_haz2;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  register_file_sb dut (
    .clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(rd1), .rd2(rd2), .bs_en(bs_en), .bs_addr(bs_addr), .busy(busy),
    .haz1(haz1), .haz2(haz2)
  );

  register_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3), .wd3(wd3),
    .rd1(nb_rd1), .rd2(nb_rd2), .bs_en(bs_en), .bs_addr(bs_addr), .busy(nb_busy),
    .haz1(nb_haz1), .haz2(nb_haz2)
  );

  register_file_sb #(.DATA_W(32), .ADDR_W(4)) dut_w (
    .clk(clk), .rst(rst), .we3(w_we3), .a1(w_a1), .a2(w_a2), .a3(w_a3), .wd3(w_wd3),
    .rd1(w_rd1), .rd2(w_rd2), .bs_en(w_bs_en), .bs_addr(w_bs_addr), .busy(w_busy),
    .haz1(w_haz1), .haz2(w_haz2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; we3 = 0; bs_en = 0; a1 = 0; a2 = 0; a3 = 0; bs_addr = 0; wd3 = 0;
    w_we3 = 0; w_bs_en = 0; w_a1 = 0; w_a2 = 0; w_a3 = 0; w_bs_addr = 0; w_wd3 = 0;

    // 1: reset then read every register on both ports
    a1 = 3'd3; bs_en = 1; bs_addr = 3'd3;
    sb_push("rst_rd1_forced", 32'd0); sb_push("rst_haz1_forced", 32'd0);
    #1; sb_pop(32'(rd1)); sb_pop(32'(haz1));
    step();
    rst = 1'b1; bs_en = 0;
    sb_push("rst_busy", 32'd0); sb_push("rst_busy_nb", 32'd0); sb_push("rst_busy_w", 32'd0);
    #1; sb_pop(32'(busy)); sb_pop(32'(nb_busy)); sb_pop(32'(w_busy));
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a); a2 = 3'(7 - a);
      sb_push("rst_rd1", 32'd0); sb_push("rst_rd2", 32'd0);
      #1; sb_pop(32'(rd1)); sb_pop(32'(rd2));
    end

    // 2: write/read, r0 hardwired
    we3 = 1; a3 = 3'd5; wd3 = 20'hABCDE; a1 = 3'd0;
    step();
    we3 = 0; a1 = 3'd5;
    sb_push("wr5_rd1", 32'h000ABCDE);
    #1; sb_pop(32'(rd1));
    we3 = 1; a3 = 3'd0; wd3 = 20'hFFFFF; a2 = 3'd0;
    sb_push("r0_byp_rd2", 32'd0);
    #1; sb_pop(32'(rd2));
    step();
    we3 = 0;
    sb_push("r0_rd2", 32'd0);
    #1; sb_pop(32'(rd2));

    // 3: bypass vs no bypass against a pending register 3
    bs_en = 1; bs_addr = 3'd3;
    step();
    bs_en = 0;
    sb_push("bs3_busy", 32'h08); sb_push("bs3_busy_nb", 32'h08);
    #1; sb_pop(32'(busy)); sb_pop(32'(nb_busy));
    we3 = 1; a3 = 3'd3; wd3 = 20'h12345; a1 = 3'd3;
    sb_push("byp_rd1", 32'h00012345); sb_push("byp_haz1", 32'd0);
    sb_push("nobyp_rd1", 32'd0);      sb_push("nobyp_haz1", 32'd1);
    #1; sb_pop(32'(rd1)); sb_pop(32'(haz1)); sb_pop(32'(nb_rd1)); sb_pop(32'(nb_haz1));
    step();
    we3 = 0;
    sb_push("wb3_busy", 32'd0); sb_push("wb3_rd1", 32'h00012345); sb_push("wb3_rd1_nb", 32'h00012345);
    #1; sb_pop(32'(busy)); sb_pop(32'(rd1)); sb_pop(32'(nb_rd1));

    // 4: scoreboard lifecycle on register 4
    bs_en = 1; bs_addr = 3'd4; a1 = 3'd4;
    sb_push("bs4_haz1_early", 32'd0);
    #1; sb_pop(32'(haz1));
    step();
    bs_en = 0;
    sb_push("bs4_busy", 32'h10); sb_push("bs4_haz1", 32'd1);
    #1; sb_pop(32'(busy)); sb_pop(32'(haz1));
    we3 = 1; a3 = 3'd4; wd3 = 20'h0BEEF;
    sb_push("wb4_haz1", 32'd0); sb_push("wb4_haz1_nb", 32'd1);
    #1; sb_pop(32'(haz1)); sb_pop(32'(nb_haz1));
    step();
    we3 = 0;
    sb_push("wb4_busy", 32'd0); sb_push("wb4_haz1_after", 32'd0);
    #1; sb_pop(32'(busy)); sb_pop(32'(haz1));

    // 5: simultaneous set and clear of register 2
    bs_en = 1; bs_addr = 3'd2;
    step();
    we3 = 1; a3 = 3'd2; wd3 = 20'h5A5A5;
    step();
    bs_en = 0; we3 = 0; a1 = 3'd2; a2 = 3'd2;
    sb_push("coll_busy", 32'h04); sb_push("coll_rd1", 32'h0005A5A5);
    sb_push("coll_rd2", 32'h0005A5A5); sb_push("coll_haz2", 32'd1);
    #1; sb_pop(32'(busy)); sb_pop(32'(rd1)); sb_pop(32'(rd2)); sb_pop(32'(haz2));
    we3 = 1; a3 = 3'd2;
    step();
    we3 = 0;

    // busy-set to r0 is ignored; top register behaves normally
    bs_en = 1; bs_addr = 3'd0; we3 = 1; a3 = 3'd7; wd3 = 20'h7E7E7;
    step();
    bs_en = 0; we3 = 0; a1 = 3'd0; a2 = 3'd7;
    sb_push("r0_bs_busy", 32'd0); sb_push("r0_haz1", 32'd0); sb_push("r7_rd2", 32'h0007E7E7);
    #1; sb_pop(32'(busy)); sb_pop(32'(haz1)); sb_pop(32'(rd2));

    // 6: mid-sequence reset discards busy bits and contents
    for (int b = 2; b < 6; b++) begin
      bs_en = 1; bs_addr = 3'(b); we3 = 1; a3 = 3'd6; wd3 = 20'h66666;
      step();
    end
    bs_en = 0; we3 = 0; a1 = 3'd6;
    sb_push("pre_rst_busy", 32'h3C); sb_push("pre_rst_rd1", 32'h00066666);
    #1; sb_pop(32'(busy)); sb_pop(32'(rd1));
    rst = 1'b0; a1 = 3'd3; we3 = 1; a3 = 3'd6; wd3 = 20'h11111; bs_en = 1; bs_addr = 3'd1;
    sb_push("in_rst_rd1", 32'd0); sb_push("in_rst_haz1", 32'd0);
    #1; sb_pop(32'(rd1)); sb_pop(32'(haz1));
    step();
    rst = 1'b1; we3 = 0; bs_en = 0;
    sb_push("post_rst_busy", 32'd0);
    #1; sb_pop(32'(busy));
    for (int a = 0; a < 8; a++) begin
      a1 = 3'(a);
      sb_push("post_rst_rd1", 32'd0);
      #1; sb_pop(32'(rd1));
    end

    // wide build: scenarios 2 and 4 on register 15
    w_we3 = 1; w_a3 = 4'd15; w_wd3 = 32'hDEADBEEF;
    step();
    w_we3 = 0; w_a1 = 4'd15;
    sb_push("w_wr15_rd1", 32'hDEADBEEF);
    #1; sb_pop(w_rd1);
    w_we3 = 1; w_a3 = 4'd0; w_wd3 = 32'hFFFFFFFF; w_a2 = 4'd0;
    step();
    w_we3 = 0;
    sb_push("w_r0_rd2", 32'd0);
    #1; sb_pop(w_rd2);
    w_bs_en = 1; w_bs_addr = 4'd15;
    step();
    w_bs_en = 0;
    sb_push("w_bs15_busy", 32'h8000); sb_push("w_bs15_haz1", 32'd1);
    #1; sb_pop(32'(w_busy)); sb_pop(32'(w_haz1));
    w_we3 = 1; w_a3 = 4'd15; w_wd3 = 32'h0F0F0F0F;
    sb_push("w_wb15_haz1", 32'd0); sb_push("w_wb15_rd1", 32'h0F0F0F0F);
    #1; sb_pop(32'(w_haz1)); sb_pop(w_rd1);
    step();
    w_we3 = 0;
    sb_push("w_wb15_busy", 32'd0);
    #1; sb_pop(32'(w_busy));

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor of the 8×20-bit datapath register file.
- Configurable data width and depth, register 0 hardwired to zero, two asynchronous read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register busy scoreboard so the decode stage can detect read-after-write hazards against in-flight writebacks.

Parameters:
DATA_W, 20, width of each register and of write/read data
ADDR_W, 3, register address width; register count NREGS = 2**ADDR_W
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes and busy-set; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset
we3  input  1  write enable (writeback)
a1  input  ADDR_W  read address, port 1
a2  input  ADDR_W  read address, port 2
a3  input  ADDR_W  write address
wd3  input  DATA_W  write data
rd1  output  DATA_W  read data, port 1 (combinational)
rd2  output  DATA_W  read data, port 2 (combinational)
bs_en  input  1  busy-set request (instruction issued with destination bs_addr)
bs_addr  input  ADDR_W  destination register being marked busy
busy  output  NREGS  scoreboard vector, bit i = register i pending
haz1  output  1  port 1 reads a pending register not satisfied by bypass
haz2  output  1  port 2 reads a pending register not satisfied by bypass

Behaviour:
Reset:
- Reset is synchronous and active-low: when rst==0 at a rising clk edge, every register clears to 0 and busy clears to all zeros.
- Writes and busy-set are ignored in that cycle.
- While rst==0, rd1, rd2, haz1 and haz2 are forced to 0 combinationally.

Write:
- At posedge clk with rst==1 and we3==1, Register[a3] <= wd3.
- Dropped when ZERO_REG==1 and a3==0.
- Full DATA_W bits written; no partial writes.

Read:
- Zero-cycle latency.
- rd1 = 0 if ZERO_REG and a1==0.
- Otherwise, if BYPASS and we3 and a1==a3, rd1 = wd3.
- Otherwise rd1 = Register[a1].
- Port 2 is identical using a2.
- Both ports may address the same register; both return identical data.

Scoreboard:
- Next-state per bit i: set if bs_en and bs_addr==i; else clear if we3 and a3==i; else hold.
- Simultaneous set and clear of the same bit: set wins (a new producer was issued).
- bs_en to register 0 is ignored when ZERO_REG==1; busy[0] then stays 0.
- busy is a registered output; it reflects a set or clear on the cycle after the edge.

Hazards:
- haz1 = busy[a1] AND NOT (BYPASS and we3 and a3==a1).
- haz2 likewise for a2.
- Register 0 never hazards when ZERO_REG==1.
- With BYPASS==0, a same-cycle writeback does not mask the hazard.

Boundaries:
- Address NREGS-1 behaves as any other register.
- No storage beyond NREGS; no out-of-range addresses exist.
- Reset asserted mid-sequence discards pending busy bits and all contents at that edge.

Test Plan:
1. Reset then read: hold rst=0 one edge, release, read all 8 registers on a1/a2 -> rd1=rd2=0 for every address, busy=8'h00.
2. Write/read and r0: we3=1, a3=5, wd3=20'hABCDE; next cycle a1=5 -> rd1=20'hABCDE. Write a3=0, wd3=20'hFFFFF; a2=0 -> rd2=0.
3. Bypass: same cycle we3=1, a3=3, wd3=20'h12345, a1=3 -> rd1=20'h12345 combinationally (BYPASS=1). With BYPASS=0 the same stimulus gives rd1 = old value (0 after reset), and haz1 stays asserted if busy[3]=1.
4. Scoreboard lifecycle: bs_en=1, bs_addr=4 -> next cycle busy[4]=1. Then a1=4 -> haz1=1. Then we3=1, a3=4 -> haz1=0 that cycle and busy[4]=0 next cycle.
5. Set/clear collision: bs_en=1, bs_addr=2 and we3=1, a3=2 same cycle with busy[2]=1 -> busy[2] remains 1; register 2 holds wd3.
6. Mid-op reset: busy=8'h3C, registers written; assert rst=0 one edge -> busy=0, all registers 0. During rst=0 with a1=3, rd1=0 and haz1=0. Parametric re-run with DATA_W=32, ADDR_W=4 repeats scenarios 2 and 4 on register 15.
